// File: rtl/ac_stage.sv
// Accumulate stage: per-channel signed accumulation of product vectors. On the
// last beat of a neuron each channel sum is scaled to fixed point and pushed
// into a 2-entry output buffer drained through a ready/valid handshake.
module ac_stage #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int CH         = 4,
   parameter int FRAC       = 8,
   parameter bit SAT        = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mu_rdy,
   output logic                       mu_ack,
   input  logic [CH*DATA_WIDTH-1:0]   mu_data,
   input  logic                       off_new,
   output logic [CH*DATA_WIDTH-1:0]   ac_out,
   output logic [CH-1:0]              ac_ovf,
   output logic                       ac_rdy,
   input  logic                       ac_ack
);

   localparam logic [ACC_WIDTH-1:0]  AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0]  AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] DatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] DatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Accumulator state
   logic [ACC_WIDTH-1:0]     acc_q [CH];
   logic [CH-1:0]            ovf_q;

   // Output buffer state
   logic [CH*DATA_WIDTH-1:0] buf_data_q [2];
   logic [CH-1:0]            buf_ovf_q [2];
   logic                     rd_ptr_q;
   logic                     wr_ptr_q;
   logic [1:0]               count_q;

   // Datapath
   logic [ACC_WIDTH:0]       ext_sum [CH];
   logic [ACC_WIDTH-1:0]     sum [CH];
   logic [ACC_WIDTH-1:0]     shifted [CH];
   logic [CH-1:0]            sum_ovf;
   logic [CH-1:0]            res_oor;
   logic [CH*DATA_WIDTH-1:0] res_data;
   logic [CH-1:0]            res_ovf;

   logic accept;
   logic push;
   logic pop;

   assign mu_ack = (count_q != 2'd2) && !reset;
   assign ac_rdy = (count_q != 2'd0) && !reset;
   assign ac_out = ac_rdy ? buf_data_q[rd_ptr_q] : '0;
   assign ac_ovf = ac_rdy ? buf_ovf_q[rd_ptr_q] : '0;

   assign accept = mu_rdy && mu_ack;
   assign push   = accept && off_new;
   assign pop    = ac_rdy && ac_ack;

   // Per-channel sum with saturate/wrap, then fixed-point conversion of the result
   always_comb begin
      res_data = '0;
      res_ovf  = '0;
      sum_ovf  = '0;
      res_oor  = '0;
      for (int i = 0; i < CH; i++) begin
         // One guard bit: the sum overflows when the top two bits disagree
         ext_sum[i] = {acc_q[i][ACC_WIDTH-1], acc_q[i]}
                    + {{(ACC_WIDTH+1-DATA_WIDTH){mu_data[i*DATA_WIDTH+DATA_WIDTH-1]}},
                       mu_data[i*DATA_WIDTH +: DATA_WIDTH]};
         sum_ovf[i] = ext_sum[i][ACC_WIDTH] ^ ext_sum[i][ACC_WIDTH-1];
         if (SAT && sum_ovf[i]) begin
            sum[i] = ext_sum[i][ACC_WIDTH] ? AccMin : AccMax;
         end else begin
            sum[i] = ext_sum[i][ACC_WIDTH-1:0];
         end
         shifted[i] = $signed(sum[i]) >>> FRAC;
         // In range only when all bits above the result sign bit match it
         res_oor[i] = !((&shifted[i][ACC_WIDTH-1:DATA_WIDTH-1]) ||
                        !(|shifted[i][ACC_WIDTH-1:DATA_WIDTH-1]));
         if (SAT && res_oor[i]) begin
            res_data[i*DATA_WIDTH +: DATA_WIDTH] = shifted[i][ACC_WIDTH-1] ? DatMin : DatMax;
         end else begin
            res_data[i*DATA_WIDTH +: DATA_WIDTH] = shifted[i][DATA_WIDTH-1:0];
         end
         res_ovf[i] = ovf_q[i] | sum_ovf[i] | res_oor[i];
      end
   end

   // Accumulators and sticky overflow flags; cleared when a neuron completes
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            acc_q[i] <= '0;
         end
         ovf_q <= '0;
      end else if (accept) begin
         for (int i = 0; i < CH; i++) begin
            acc_q[i] <= off_new ? '0 : sum[i];
         end
         ovf_q <= off_new ? '0 : (ovf_q | sum_ovf);
      end
   end

   // Two-entry output FIFO; push and pop together keep the occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_data_q[0] <= '0;
         buf_data_q[1] <= '0;
         buf_ovf_q[0]  <= '0;
         buf_ovf_q[1]  <= '0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
      end else begin
         if (push) begin
            buf_data_q[wr_ptr_q] <= res_data;
            buf_ovf_q[wr_ptr_q]  <= res_ovf;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_ac_stage.sv
// Self-checking bench for ac_stage: a behavioural model pushes expected results
// into a scoreboard, a negedge monitor pops and compares on each handshake.
module tb_ac_stage;

   localparam longint AMax = 64'sd2147483647;
   localparam longint AMin = -AMax - 1;
   localparam longint DMax = 64'sd32767;
   localparam longint DMin = -DMax - 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        mu_rdy;
   logic [63:0] mu_data;
   logic        off_new;
   logic        ac_ack;

   logic        mu_ack,  mu_ack_w;
   logic [63:0] ac_out,  ac_out_w;
   logic [3:0]  ac_ovf,  ac_ovf_w;
   logic        ac_rdy,  ac_rdy_w;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;

   logic [67:0] sb [$];
   logic [67:0] mon_exp;
   logic        hold_q = 1'b0;
   logic [63:0] hold_out;
   logic [3:0]  hold_ovf;

   longint m_acc [4];
   bit     m_ovf [4];

   always #5 clk = ~clk;

   ac_stage #(.SAT(1'b1)) dut (
      .clk     (clk),
      .reset   (reset),
      .mu_rdy  (mu_rdy),
      .mu_ack  (mu_ack),
      .mu_data (mu_data),
      .off_new (off_new),
      .ac_out  (ac_out),
      .ac_ovf  (ac_ovf),
      .ac_rdy  (ac_rdy),
      .ac_ack  (ac_ack)
   );

   ac_stage #(.SAT(1'b0)) dut_w (
      .clk     (clk),
      .reset   (reset),
      .mu_rdy  (mu_rdy),
      .mu_ack  (mu_ack_w),
      .mu_data (mu_data),
      .off_new (off_new),
      .ac_out  (ac_out_w),
      .ac_ovf  (ac_ovf_w),
      .ac_rdy  (ac_rdy_w),
      .ac_ack  (ac_ack)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Monitor: scoreboard compare on each pop, head stability while stalled
   always @(negedge clk) begin
      if (reset) begin
         hold_q = 1'b0;
      end else begin
         if (hold_q) begin
            n_checks++;
            if (ac_out !== hold_out || ac_ovf !== hold_ovf || ac_rdy !== 1'b1) begin
               n_fail++;
               $display("FAIL hold_stable: got %h/%b rdy %b expected %h/%b rdy 1",
                        ac_out, ac_ovf, ac_rdy, hold_out, hold_ovf);
            end
         end
         if (ac_rdy && ac_ack) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_result: got %h expected none", ac_out);
            end else begin
               mon_exp = sb.pop_front();
               n_pops++;
               if ({ac_out, ac_ovf} !== mon_exp) begin
                  n_fail++;
                  $display("FAIL scoreboard: got %h/%b expected %h/%b",
                           ac_out, ac_ovf, mon_exp[67:4], mon_exp[3:0]);
               end
            end
         end
         hold_q   = ac_rdy && !ac_ack;
         hold_out = ac_out;
         hold_ovf = ac_ovf;
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_acc[i] = 0;
         m_ovf[i] = 1'b0;
      end
      sb.delete();
   endtask

   // Saturating reference model (SAT=1, FRAC=8)
   task automatic model_beat(input logic [63:0] d, input logic last);
      logic [63:0] exp_d;
      logic [3:0]  exp_o;
      longint      s;
      longint      r;
      bit          so;
      exp_d = '0;
      exp_o = '0;
      for (int i = 0; i < 4; i++) begin
         s  = m_acc[i] + longint'($signed(d[i*16 +: 16]));
         so = 1'b0;
         if (s > AMax) begin s = AMax; so = 1'b1; end
         if (s < AMin) begin s = AMin; so = 1'b1; end
         if (last) begin
            r = s >>> 8;
            exp_o[i] = m_ovf[i] | so;
            if (r > DMax) begin r = DMax; exp_o[i] = 1'b1; end
            if (r < DMin) begin r = DMin; exp_o[i] = 1'b1; end
            exp_d[i*16 +: 16] = r[15:0];
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
         end else begin
            m_acc[i] = s;
            m_ovf[i] = m_ovf[i] | so;
         end
      end
      if (last) sb.push_back({exp_d, exp_o});
   endtask

   // Drive one beat from posedge+1 and hold it until accepted; returns at posedge+1
   task automatic beat(input logic [63:0] d, input logic last);
      int w = 0;
      mu_rdy  = 1'b1;
      mu_data = d;
      off_new = last;
      @(negedge clk);
      while (!mu_ack && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!mu_ack) begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_timeout: got mu_ack 0 expected 1 within 50 cycles");
      end else begin
         model_beat(d, last);
      end
      @(posedge clk);
      #1;
      mu_rdy  = 1'b0;
      off_new = 1'b0;
      mu_data = '0;
   endtask

   task automatic drain();
      int w = 0;
      ac_ack = 1'b1;
      @(negedge clk);
      while (ac_rdy && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      ac_ack = 1'b0;
      n_checks++;
      if (ac_rdy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got rdy %b pending %0d expected rdy 0 pending 0",
                  ac_rdy, sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ac_rdy, mu_ack, ac_out, ac_ovf} !== 70'd0) begin
         n_fail++;
         $display("FAIL reset_state: got rdy %b ack %b out %h ovf %b expected all 0",
                  ac_rdy, mu_ack, ac_out, ac_ovf);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (mu_ack !== 1'b1 || ac_rdy !== 1'b0 || mu_ack_w !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset: got ack %b rdy %b expected ack 1 rdy 0", mu_ack, ac_rdy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      ac_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         beat(64'h0000_0000_FF00_0100, k == 2);
      end
      n_checks++;
      if (ac_rdy !== 1'b1 || ac_out !== 64'h0000_0000_FFFD_0003 || ac_ovf !== 4'b0000) begin
         n_fail++;
         $display("FAIL basic_sum: got rdy %b out %h ovf %b expected 1 0000_0000_fffd_0003 0000",
                  ac_rdy, ac_out, ac_ovf);
      end
      drain();
   endtask

   task automatic test_saturation();
      ac_ack = 1'b0;
      for (int k = 0; k < 300; k++) begin
         beat(64'h0000_0000_8000_7FFF, k == 299);
      end
      n_checks++;
      if (ac_out !== 64'h0000_0000_8000_7FFF || ac_ovf !== 4'b0011) begin
         n_fail++;
         $display("FAIL sat_result: got %h/%b expected 0000_0000_8000_7fff/0011", ac_out, ac_ovf);
      end
      n_checks++;
      if (ac_out_w !== 64'h0000_0000_6A00_95FE || ac_ovf_w !== 4'b0011) begin
         n_fail++;
         $display("FAIL wrap_result: got %h/%b expected 0000_0000_6a00_95fe/0011",
                  ac_out_w, ac_ovf_w);
      end
      drain();
      beat(64'h0000_0000_0000_0100, 1'b1);
      n_checks++;
      if (ac_out !== 64'h1 || ac_ovf !== 4'b0000 || ac_out_w !== 64'h1 || ac_ovf_w !== 4'b0000) begin
         n_fail++;
         $display("FAIL sat_next_neuron: got %h/%b wrap %h/%b expected 1/0000",
                  ac_out, ac_ovf, ac_out_w, ac_ovf_w);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int pops0;
      pops0  = n_pops;
      ac_ack = 1'b0;
      beat(64'h0000_0000_FF00_0100, 1'b1);
      beat(64'h0000_0000_FE00_0200, 1'b1);
      fork
         beat(64'h0000_0000_FD00_0300, 1'b1);
         begin
            @(negedge clk);
            n_checks++;
            if (mu_ack !== 1'b0 || ac_out[15:0] !== 16'h0001) begin
               n_fail++;
               $display("FAIL bp_full: got ack %b head %h expected ack 0 head 0001",
                        mu_ack, ac_out[15:0]);
            end
            repeat (2) @(negedge clk);
            n_checks++;
            if (mu_ack !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_hold: got ack %b expected 0", mu_ack);
            end
            @(posedge clk);
            #1;
            ac_ack = 1'b1;
         end
      join
      drain();
      n_checks++;
      if (n_pops - pops0 != 3) begin
         n_fail++;
         $display("FAIL bp_count: got %0d results expected 3", n_pops - pops0);
      end
   endtask

   task automatic test_streaming();
      int run = 0;
      ac_ack = 1'b1;
      fork
         for (int k = 0; k < 8; k++) begin
            beat({$urandom, $urandom}, 1'b1);
         end
         begin
            int w = 0;
            @(negedge clk);
            while (!ac_rdy && w < 20) begin
               @(negedge clk);
               w++;
            end
            while (ac_rdy && run < 20) begin
               run++;
               @(negedge clk);
            end
         end
      join
      drain();
      n_checks++;
      if (run != 8) begin
         n_fail++;
         $display("FAIL stream_run: got %0d consecutive valid cycles expected 8", run);
      end
   endtask

   task automatic test_reset_mid();
      ac_ack = 1'b0;
      beat(64'h0000_0000_0000_0500, 1'b1);
      beat(64'h0000_0000_0000_0100, 1'b0);
      beat(64'h0000_0000_0000_0100, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ac_rdy !== 1'b0 || mu_ack !== 1'b0 || ac_out !== 64'h0) begin
         n_fail++;
         $display("FAIL mid_reset: got rdy %b ack %b out %h expected 0 0 0", ac_rdy, mu_ack, ac_out);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      beat(64'h0000_0000_0000_0200, 1'b1);
      n_checks++;
      if (ac_rdy !== 1'b1 || ac_out !== 64'h2 || ac_ovf !== 4'b0000) begin
         n_fail++;
         $display("FAIL after_reset_sum: got rdy %b out %h ovf %b expected 1 2 0000",
                  ac_rdy, ac_out, ac_ovf);
      end
      drain();
   endtask

   initial begin
      reset   = 1'b1;
      mu_rdy  = 1'b0;
      mu_data = '0;
      off_new = 1'b0;
      ac_ack  = 1'b0;
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_streaming();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ac_stage.md
# ac_stage

Parametrised accumulate stage for the neuron pipeline. It sits between the multiply stage and the activation stage and sums CH channels of signed products in parallel. When the multiply stage flags the last product of a neuron, it converts each channel's sum to fixed point and emits it through a 2-entry output buffer. Unlike the earlier single-register accumulate stage, it adds configurable widths and channel count, saturating or wrapping arithmetic, per-channel overflow flags, and a ready/valid handshake with downstream backpressure.

## Interface
- DATA_WIDTH, 16, width of each input product and each output result (signed two's complement)
- ACC_WIDTH, 32, internal accumulator width per channel; must be greater than DATA_WIDTH
- CH, 4, number of parallel channels
- FRAC, 8, arithmetic right shift applied to the sum at output conversion
- SAT, 1, 1 = saturate on overflow, 0 = wrap/truncate
- clk  in  1  clock; single clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mu_rdy  in  1  product vector valid
- mu_ack  out  1  stage can accept a product vector
- mu_data  in  CH*DATA_WIDTH  products; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- off_new  in  1  qualified by mu_rdy; marks the current beat as the last of the neuron
- ac_out  out  CH*DATA_WIDTH  result vector at the buffer head
- ac_ovf  out  CH  per-channel overflow flag for the result at the buffer head
- ac_rdy  out  1  ac_out/ac_ovf valid
- ac_ack  in  1  downstream accepts the head result

## Operation
- Accept: a beat is accepted when mu_rdy && mu_ack. mu_ack = (count != 2) && !reset.
- Accumulation, per channel:
  - sum = acc_i + sign-extended mu_data_i.
  - SAT=1: clamp to the ACC_WIDTH signed range.
  - SAT=0: wrap modulo 2^ACC_WIDTH.
  - Any out-of-range sum sets the sticky flag ovf_i.
- Accepted beat without off_new: acc_i <= sum.
- Accepted beat with off_new:
  - The result is built from sum, so the final beat is included.
  - r = sum >>> FRAC.
  - SAT=1: clamp r to the DATA_WIDTH signed range. SAT=0: take the low DATA_WIDTH bits of r.
  - Pushed flag = ovf_i | sum overflow | (r out of DATA_WIDTH range).
  - acc_i and ovf_i clear to 0 in the same cycle.
- Output buffer: 2-entry FIFO, count 0..2, head drives ac_out/ac_ovf. ac_rdy = (count != 0).
  - Pop occurs on ac_rdy && ac_ack.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push is impossible at count==2 because mu_ack=0.
- Channels are fully independent; there is no cross-channel arithmetic.
- Beats without mu_rdy leave all state unchanged.

## Timing
- Reset values: ac_out=0, ac_ovf=0, ac_rdy=0, mu_ack=0 while reset is high. Internally acc=0, ovf=0, count=0.
- mu_ack=1 in the first cycle after reset deasserts.
- Reset mid-operation discards partial sums and buffered results, with no output pulse.
- Latency: off_new beat accepted at edge k with an empty buffer gives ac_rdy=1 and a valid ac_out after edge k.
- Throughput: one beat per cycle. Back-to-back off_new beats with ac_ack held at 1 give one result per cycle.
- mu_ack is a registered-state function, with no combinational path from ac_ack. It rises the cycle after a pop that leaves count<2.
- ac_out/ac_ovf are stable while ac_rdy=1 and ac_ack=0.
- Downstream may hold ac_ack=1 continuously. With ac_rdy=0, ac_ack has no effect.

## Test plan
Defaults unless stated: CH=4, DATA_WIDTH=16, ACC_WIDTH=32, FRAC=8, SAT=1.
- Basic sum: ch0 gets 0x0100 ×3 (off_new on the 3rd), ch1 gets 0xFF00 ×3, ch2/ch3 get 0. One cycle after the 3rd accept: ac_rdy=1, ac_out ch0=0x0003, ch1=0xFFFD, ch2=ch3=0, ac_ovf=0.
- Output saturation: ch0 gets 0x7FFF ×300 and ch1 gets 0x8000 ×300, off_new on the last beat. Expect ch0=0x7FFF, ch1=0x8000, ac_ovf=4'b0011. The next neuron starts from 0 with ovf clear.
- Wrap mode (SAT=0), same stimulus as the saturation test: ch0=0x95FE (low 16 bits of 38398), ch1=0x6A00, ac_ovf=4'b0011.
- Backpressure: ac_ack=0, three single-beat neurons with values 1, 2, 3 (shifted by <<8).
  - mu_ack drops after the 2nd result, and the 3rd beat is held with mu_rdy asserted.
  - Raise ac_ack: outputs 1, 2, 3 in order. The 3rd beat is accepted once mu_ack returns.
  - No loss or duplication.
- Streaming: 8 consecutive single-beat neurons with ac_ack=1. ac_rdy stays high for 8 consecutive cycles, each result matching its input >>> 8.
- Reset mid-accumulation: 2 beats of 0x0100 on ch0, reset for 1 cycle, then 1 beat of 0x0200 with off_new. Result ch0=0x0002. During reset, ac_rdy=0 and mu_ack=0.
